// File: rtl/tone_synth.sv
// Direct-digital-synthesis tone generator: phase accumulator on a programmable
// sample tick, sine/square/triangle/sawtooth shaper, power-of-two attenuation.
module tone_synth #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [1:0]         cfg_wave,
  input  logic [1:0]         cfg_atten,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid
);

  localparam int  N     = 1 << ADDR_W;
  localparam int  M     = 1 << (DATA_W - 1);
  localparam int  A     = M - 1;
  localparam real PI    = 3.14159265358979323846;
  // Only the top phase bits ever reach the shaper, so only those are staged.
  localparam int  TOP_W = (DATA_W + 1 > ADDR_W) ? DATA_W + 1 : ADDR_W;

  localparam logic [ADDR_W:0]        QN1 = (ADDR_W + 1)'(N / 4);
  localparam logic [ADDR_W:0]        QN2 = (ADDR_W + 1)'(N / 2);
  localparam logic [ADDR_W:0]        QN3 = (ADDR_W + 1)'(3 * N / 4);
  localparam logic [ADDR_W:0]        QN4 = (ADDR_W + 1)'(N);
  localparam logic signed [DATA_W:0] M_S = (DATA_W + 1)'(M);

  typedef enum logic [1:0] {WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW} wave_e;

  typedef struct packed {
    logic [PHASE_W-1:0] step;
    logic [DIV_W-1:0]   div;
    wave_e              wave;
    logic [1:0]         atten;
  } cfg_t;

  function automatic int q_val(input int k);
    real r;
    r = real'(A) * $sin(2.0 * PI * real'(k) / real'(N));
    return $rtoi(r + 0.5);
  endfunction

  logic [DATA_W-1:0] qtab [N/4+1];
  for (genvar k = 0; k <= N / 4; k++) begin : g_qtab
    assign qtab[k] = DATA_W'(q_val(k));
  end

  cfg_t               act, shadow, cfg_in;
  logic               pending;
  logic [PHASE_W-1:0] phase;
  logic [DIV_W-1:0]   count;
  logic               tick, apply, accept;

  logic               s1_valid;
  logic [TOP_W-1:0]   s1_top;
  wave_e              s1_wave;
  logic [1:0]         s1_atten;

  assign cfg_in    = '{step: cfg_step, div: cfg_div, wave: wave_e'(cfg_wave), atten: cfg_atten};
  assign cfg_ready = !pending;
  assign tick      = enable && (count == '0);
  // While running, a new config lands on a tick so the divider reloads with it.
  assign apply     = pending && (enable ? tick : 1'b1);
  assign accept    = cfg_valid && !pending;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      count        <= '0;
      act          <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      s1_valid     <= 1'b0;
      s1_top       <= '0;
      s1_wave      <= WAVE_SINE;
      s1_atten     <= '0;
      sample       <= DATA_W'(M);
      sample_valid <= 1'b0;
    end else begin
      if (tick) begin
        phase <= phase + act.step;
        count <= apply ? shadow.div : act.div;
      end else if (enable) begin
        count <= count - 1'b1;
      end

      if (apply) begin
        act     <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= cfg_in;
        pending <= 1'b1;
      end

      s1_valid <= tick;
      if (tick) begin
        s1_top   <= phase[PHASE_W-1 -: TOP_W];
        s1_wave  <= act.wave;
        s1_atten <= act.atten;
      end

      sample_valid <= s1_valid;
      if (s1_valid) sample <= shaped;
    end
  end

  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W:0]          qi;
  logic                     neg;
  logic [DATA_W-1:0]        q;
  logic [DATA_W-1:0]        tri_t;
  logic [DATA_W-1:0]        s;
  logic signed [DATA_W:0]   diff, shifted, sum;
  logic [DATA_W-1:0]        shaped;

  assign idx   = s1_top[TOP_W-1 -: ADDR_W];
  assign tri_t = s1_top[TOP_W-2 -: DATA_W];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    qi  = '0;
    neg = 1'b0;
    if ({1'b0, idx} <= QN1) begin
      qi = {1'b0, idx};
    end else if ({1'b0, idx} < QN2) begin
      qi = QN2 - {1'b0, idx};
    end else if ({1'b0, idx} <= QN3) begin
      qi  = {1'b0, idx} - QN2;
      neg = 1'b1;
    end else begin
      qi  = QN4 - {1'b0, idx};
      neg = 1'b1;
    end
  end

  assign q = qtab[qi[ADDR_W-2:0]];

  always_comb begin
    s = DATA_W'(M);
    case (s1_wave)
      WAVE_SINE:   s = neg ? DATA_W'(M) - q : DATA_W'(M) + q;
      WAVE_SQUARE: s = s1_top[TOP_W-1] ? '0 : '1;
      WAVE_TRI:    s = s1_top[TOP_W-1] ? ~tri_t : tri_t;
      WAVE_SAW:    s = s1_top[TOP_W-1 -: DATA_W];
      default:     s = DATA_W'(M);
    endcase
  end

  // Attenuation is an arithmetic shift around mid-scale, so it never overflows.
  assign diff    = $signed({1'b0, s}) - M_S;
  assign shifted = diff >>> s1_atten;
  assign sum     = shifted + M_S;
  assign shaped  = sum[DATA_W-1:0];

endmodule
